// File: rtl/vga_grid_timing_pkg.sv
// Shared definitions for the Snake VGA display path: standard mode timings,
// the colour record and the fixed palette used by the grid renderer.
package vga_pkg;

  localparam int unsigned VGA_CW = 4;

  // 640x480 @ 60 Hz, 25.175 MHz
  localparam int unsigned M640_H_SYNC   = 96;
  localparam int unsigned M640_H_BACK   = 48;
  localparam int unsigned M640_H_ACTIVE = 640;
  localparam int unsigned M640_H_FRONT  = 16;
  localparam int unsigned M640_V_SYNC   = 2;
  localparam int unsigned M640_V_BACK   = 33;
  localparam int unsigned M640_V_ACTIVE = 480;
  localparam int unsigned M640_V_FRONT  = 10;

  // 800x600 @ 60 Hz, 40 MHz
  localparam int unsigned M800_H_SYNC   = 128;
  localparam int unsigned M800_H_BACK   = 88;
  localparam int unsigned M800_H_ACTIVE = 800;
  localparam int unsigned M800_H_FRONT  = 40;
  localparam int unsigned M800_V_SYNC   = 4;
  localparam int unsigned M800_V_BACK   = 23;
  localparam int unsigned M800_V_ACTIVE = 600;
  localparam int unsigned M800_V_FRONT  = 1;

  // 1280x1024 @ 60 Hz, 108 MHz
  localparam int unsigned M1280_H_SYNC   = 112;
  localparam int unsigned M1280_H_BACK   = 248;
  localparam int unsigned M1280_H_ACTIVE = 1280;
  localparam int unsigned M1280_H_FRONT  = 48;
  localparam int unsigned M1280_V_SYNC   = 3;
  localparam int unsigned M1280_V_BACK   = 38;
  localparam int unsigned M1280_V_ACTIVE = 1024;
  localparam int unsigned M1280_V_FRONT  = 1;

  typedef struct packed {
    logic [VGA_CW-1:0] r;
    logic [VGA_CW-1:0] g;
    logic [VGA_CW-1:0] b;
  } rgb_t;

  localparam rgb_t BLACK = '{r: '0, g: '0, b: '0};
  localparam rgb_t RED   = '{r: '1, g: '0, b: '0};
  localparam rgb_t GREEN = '{r: '0, g: '1, b: '0};

  // Bar order white, yellow, cyan, green, magenta, red, blue, black falls out
  // of inverting individual index bits.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    c.r = {VGA_CW{~idx[1]}};
    c.g = {VGA_CW{~idx[2]}};
    c.b = {VGA_CW{~idx[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_grid_timing_if.sv
// Box-position inputs and video outputs of the grid renderer.
// Optional macro VGA_TEST_PATTERN_EN adds the pattern select line.
interface vga_grid_if #(
  parameter int unsigned CW     = 4,
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned CELL_W = 7
);
  logic [CELL_W-1:0] box_x;
  logic [CELL_W-1:0] box_y;
  logic              box_en;
`ifdef VGA_TEST_PATTERN_EN
  logic              pattern;
`endif
  logic [CW-1:0]     red;
  logic [CW-1:0]     green;
  logic [CW-1:0]     blue;
  logic              hs;
  logic              vs;
  logic              de;
  logic [CNT_W-1:0]  x;
  logic [CNT_W-1:0]  y;
  logic              frame_start;

  // Renderer side
  modport master (
`ifdef VGA_TEST_PATTERN_EN
    input  pattern,
`endif
    input  box_x, box_y, box_en,
    output red, green, blue, hs, vs, de, x, y, frame_start
  );

  // Game logic / display side
  modport slave (
`ifdef VGA_TEST_PATTERN_EN
    output pattern,
`endif
    output box_x, box_y, box_en,
    input  red, green, blue, hs, vs, de, x, y, frame_start
  );
endinterface

// File: rtl/vga_grid_timing_core.sv
// Raster counters with registered sync, data-enable and coordinates.
// The unregistered pixel_* view lets the parent compute colour in the same
// stage so that RGB lands aligned with the registered outputs here.
module vga_timing_core #(
  parameter int unsigned H_SYNC   = 112,
  parameter int unsigned H_BACK   = 248,
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FRONT  = 48,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BACK   = 38,
  parameter int unsigned V_ACTIVE = 1024,
  parameter int unsigned V_FRONT  = 1,
  parameter int unsigned CNT_W    = 12,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start,
  output logic             pix_de,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_tick
);

  localparam logic [CNT_W-1:0] HLast  = CNT_W'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
  localparam logic [CNT_W-1:0] VLast  = CNT_W'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
  localparam logic [CNT_W-1:0] HSyncE = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VSyncE = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HStart = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] VStart = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] HEnd   = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [CNT_W-1:0] VEnd   = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             h_act, v_act;

  // Next counter state: line counter wraps every line, frame counter on line end
  always_comb begin
    h_cnt_d = (h_cnt_q == HLast) ? '0 : h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HLast) begin
      v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Active window and coordinates of the current counter state
  always_comb begin
    h_act      = (h_cnt_q >= HStart) && (h_cnt_q < HEnd);
    v_act      = (v_cnt_q >= VStart) && (v_cnt_q < VEnd);
    pix_de     = h_act && v_act;
    pix_x      = pix_de ? h_cnt_q - HStart : '0;
    pix_y      = pix_de ? v_cnt_q - VStart : '0;
    frame_tick = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // Output stage, one cycle behind the counters
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      hs          <= (h_cnt_q < HSyncE) ? HS_POL : ~HS_POL;
      vs          <= (v_cnt_q < VSyncE) ? VS_POL : ~VS_POL;
      de          <= pix_de;
      x           <= pix_x;
      y           <= pix_y;
      frame_start <= pix_de && (pix_x == '0) && (pix_y == '0);
    end
  end

endmodule

// File: rtl/vga_grid_timing.sv
// VGA timing generator plus grid renderer: red one-cell border and one green
// box in cell units, box position latched once per frame to avoid tearing.
// Optional macro VGA_TEST_PATTERN_EN adds frame-latched colour bars.
module vga_grid_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC    = M1280_H_SYNC,
  parameter int unsigned H_BACK    = M1280_H_BACK,
  parameter int unsigned H_ACTIVE  = M1280_H_ACTIVE,
  parameter int unsigned H_FRONT   = M1280_H_FRONT,
  parameter int unsigned V_SYNC    = M1280_V_SYNC,
  parameter int unsigned V_BACK    = M1280_V_BACK,
  parameter int unsigned V_ACTIVE  = M1280_V_ACTIVE,
  parameter int unsigned V_FRONT   = M1280_V_FRONT,
  parameter int unsigned GRID_LOG2 = 4,
  parameter int unsigned CW        = 4,
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned CELL_W    = 7,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0
) (
  input logic        I_clk,
  input logic        I_rst_n,
  vga_grid_if.master bus
);

  localparam logic [CNT_W-1:0] HLastCell = CNT_W'((H_ACTIVE >> GRID_LOG2) - 1);
  localparam logic [CNT_W-1:0] VLastCell = CNT_W'((V_ACTIVE >> GRID_LOG2) - 1);

  if ((H_ACTIVE % (1 << GRID_LOG2)) != 0 || (V_ACTIVE % (1 << GRID_LOG2)) != 0) begin : g_bad_grid
    $error("H_ACTIVE and V_ACTIVE must be multiples of the grid cell size");
  end

  logic             hs, vs, de, frame_start;
  logic [CNT_W-1:0] x, y;
  logic             pix_de, frame_tick;
  logic [CNT_W-1:0] pix_x, pix_y;

  vga_timing_core #(
    .H_SYNC  (H_SYNC),
    .H_BACK  (H_BACK),
    .H_ACTIVE(H_ACTIVE),
    .H_FRONT (H_FRONT),
    .V_SYNC  (V_SYNC),
    .V_BACK  (V_BACK),
    .V_ACTIVE(V_ACTIVE),
    .V_FRONT (V_FRONT),
    .CNT_W   (CNT_W),
    .HS_POL  (HS_POL),
    .VS_POL  (VS_POL)
  ) u_core (
    .I_clk      (I_clk),
    .I_rst_n    (I_rst_n),
    .hs         (hs),
    .vs         (vs),
    .de         (de),
    .x          (x),
    .y          (y),
    .frame_start(frame_start),
    .pix_de     (pix_de),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_tick (frame_tick)
  );

  logic [CELL_W-1:0] box_x_q, box_y_q;
  logic              box_en_q;
`ifdef VGA_TEST_PATTERN_EN
  logic              pattern_q;
  logic [CNT_W-1:0]  bar;
`endif

  // Frame latch: sample game inputs only at raster origin
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      box_x_q   <= '0;
      box_y_q   <= '0;
      box_en_q  <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      pattern_q <= 1'b0;
`endif
    end else if (frame_tick) begin
      box_x_q   <= bus.box_x;
      box_y_q   <= bus.box_y;
      box_en_q  <= bus.box_en;
`ifdef VGA_TEST_PATTERN_EN
      pattern_q <= bus.pattern;
`endif
    end
  end

  logic [CNT_W-1:0] cell_x, cell_y;
  logic             border, on_box;
  rgb_t             grid_c, pix_c;

  // Colour of the current counter state; border beats box, blanking is black
  always_comb begin
    cell_x = pix_x >> GRID_LOG2;
    cell_y = pix_y >> GRID_LOG2;
    border = (cell_x == '0) || (cell_x == HLastCell) ||
             (cell_y == '0) || (cell_y == VLastCell);
    on_box = box_en_q && (cell_x == CNT_W'(box_x_q)) && (cell_y == CNT_W'(box_y_q));
    if (border)      grid_c = RED;
    else if (on_box) grid_c = GREEN;
    else             grid_c = BLACK;
`ifdef VGA_TEST_PATTERN_EN
    bar = pix_x / CNT_W'(H_ACTIVE / 8);
    if (pattern_q) grid_c = bar_colour(bar[2:0]);
`endif
    pix_c = pix_de ? grid_c : BLACK;
  end

  logic [CW-1:0] red_q, green_q, blue_q;

  // Colour register, aligned with the core's registered outputs
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      red_q   <= {CW{|pix_c.r}};
      green_q <= {CW{|pix_c.g}};
      blue_q  <= {CW{|pix_c.b}};
    end
  end

  assign bus.red         = red_q;
  assign bus.green       = green_q;
  assign bus.blue        = blue_q;
  assign bus.hs          = hs;
  assign bus.vs          = vs;
  assign bus.de          = de;
  assign bus.x           = x;
  assign bus.y           = y;
  assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_vga_grid_timing.sv
// Bench for vga_grid_timing on a reduced 64x48 mode with 8-pixel cells
// (8x6 grid) so whole frames stay short.
module tb_vga_grid_timing;

  localparam int unsigned HS = 4, HB = 4, HA = 64, HF = 4;
  localparam int unsigned VS = 2, VB = 2, VA = 48, VF = 1;
  localparam int unsigned HTOT   = 76;                // 4+4+64+4
  localparam int unsigned FRAME  = 4028;              // 76*53
  localparam int unsigned FS_LAT = 4 * 76 + 8 + 1;    // first active pixel + output register

  localparam logic [11:0] C_RED = 12'hF00, C_GRN = 12'h0F0, C_BLK = 12'h000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_grid_if #(.CW(4), .CNT_W(12), .CELL_W(7)) bus ();

  vga_grid_timing #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .GRID_LOG2(3), .CW(4), .CNT_W(12), .CELL_W(7), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .I_clk  (clk),
    .I_rst_n(rst_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          bx;
    int          by;
    bit          en;
    int          px;
    int          py;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int rgb_now();
    return int'({bus.red, bus.green, bus.blue});
  endfunction

  // Step on falling edges until the output pixel (tx,ty) is shown
  task automatic seek(input int tx, input int ty, output bit ok);
    int n = 0;
    ok = 1'b1;
    while (!(bus.de && int'(bus.x) == tx && int'(bus.y) == ty)) begin
      if (n > 2 * FRAME) begin
        ok = 1'b0;
        n_vec++;
        n_bad++;
        $display("FAIL seek(%0d,%0d): pixel not reached in %0d cycles", tx, ty, n);
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_start && n <= 2 * FRAME);
    if (!bus.frame_start) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_fs: no frame_start in %0d cycles", n);
    end
  endtask

  task automatic measure_fs(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.frame_start && n < 2 * FRAME);
    check(name, n, FS_LAT);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " hs"}, bus.hs, 1);
    check({tag, " vs"}, bus.vs, 1);
    check({tag, " de"}, bus.de, 0);
    check({tag, " x"}, int'(bus.x), 0);
    check({tag, " y"}, int'(bus.y), 0);
    check({tag, " rgb"}, rgb_now(), 0);
    check({tag, " frame_start"}, bus.frame_start, 0);
  endtask

  task automatic set_box(input int bx, input int by, input bit en);
    bus.box_x  = 7'(bx);
    bus.box_y  = 7'(by);
    bus.box_en = en;
  endtask

  task automatic probe(input string name, input int px, input int py, input logic [11:0] exp);
    bit ok;
    seek(px, py, ok);
    if (ok) check(name, rgb_now(), int'(exp));
  endtask

  initial begin
    int n_hs, n_vs, n_de, n_fs, n_x0, n_y0, max_x, max_y;
    int cbx, cby;
    bit cen, ok;

    // Box cells: x 8c..8c+7, y 8r..8r+7; border cols 0,7 and rows 0,5
    vecs[0]  = '{3, 2, 1'b1,  0,  0, C_RED};
    vecs[1]  = '{3, 2, 1'b1, 10,  3, C_RED};
    vecs[2]  = '{3, 2, 1'b1,  9,  8, C_BLK};
    vecs[3]  = '{3, 2, 1'b1, 24, 16, C_GRN};
    vecs[4]  = '{3, 2, 1'b1, 32, 16, C_BLK};
    vecs[5]  = '{3, 2, 1'b1, 23, 20, C_BLK};
    vecs[6]  = '{3, 2, 1'b1, 31, 23, C_GRN};
    vecs[7]  = '{3, 2, 1'b1, 28, 24, C_BLK};
    vecs[8]  = '{3, 2, 1'b1, 56, 30, C_RED};
    vecs[9]  = '{3, 2, 1'b1, 39, 39, C_BLK};
    vecs[10] = '{3, 2, 1'b1, 40, 40, C_RED};
    vecs[11] = '{3, 2, 1'b1, 63, 47, C_RED};
    vecs[12] = '{0, 0, 1'b1,  4,  4, C_RED};
    vecs[13] = '{0, 0, 1'b1, 12,  4, C_RED};
    vecs[14] = '{0, 0, 1'b1,  8,  8, C_BLK};
    vecs[15] = '{10, 3, 1'b1, 48, 24, C_BLK};
    vecs[16] = '{10, 3, 1'b1, 50, 28, C_BLK};
    vecs[17] = '{6, 4, 1'b1, 47, 32, C_BLK};
    vecs[18] = '{6, 4, 1'b1, 48, 32, C_GRN};
    vecs[19] = '{6, 4, 1'b1, 55, 39, C_GRN};
    vecs[20] = '{6, 4, 1'b1, 56, 39, C_RED};
    vecs[21] = '{6, 4, 1'b1, 48, 40, C_RED};
    vecs[22] = '{3, 2, 1'b0, 24, 16, C_BLK};
    vecs[23] = '{3, 2, 1'b0, 31, 23, C_BLK};

    set_box(3, 2, 1'b1);
    repeat (3) @(negedge clk);
    check_reset("reset");

    rst_n = 1'b1;
    measure_fs("release to frame_start");

    // One full frame period from the first active pixel
    n_hs = 0; n_vs = 0; n_de = 0; n_fs = 0; n_x0 = 0; n_y0 = 0; max_x = 0; max_y = 0;
    for (int i = 0; i < int'(FRAME); i++) begin
      if (!bus.hs) n_hs++;
      if (!bus.vs) n_vs++;
      if (bus.frame_start) n_fs++;
      if (bus.de) begin
        n_de++;
        if (bus.x == 0) n_x0++;
        if (bus.y == 0) n_y0++;
        if (int'(bus.x) > max_x) max_x = int'(bus.x);
        if (int'(bus.y) > max_y) max_y = int'(bus.y);
      end
      @(posedge clk);
      #1;
    end
    check("hs low cycles/frame", n_hs, 4 * 53);
    check("vs low cycles/frame", n_vs, 2 * int'(HTOT));
    check("de cycles/frame", n_de, 64 * 48);
    check("frame_start pulses", n_fs, 1);
    check("lines with x=0", n_x0, 48);
    check("pixels with y=0", n_y0, 64);
    check("max x", max_x, 63);
    check("max y", max_y, 47);
    check("frame_start period", bus.frame_start, 1);

    // Mid-frame box move only shows from the following frame
    @(negedge clk);
    seek(0, 10, ok);
    set_box(5, 4, 1'b1);
    probe("old box kept", 24, 16, C_GRN);
    probe("new box not yet", 40, 32, C_BLK);
    probe("old box gone", 24, 16, C_BLK);
    probe("new box shown", 40, 32, C_GRN);
    cbx = 5; cby = 4; cen = 1'b1;

    // Table; each config group starts from an active pixel, so the next
    // frame_start belongs to a frame latched with the new inputs
    for (int i = 0; i < 24; i++) begin
      if (vecs[i].bx != cbx || vecs[i].by != cby || vecs[i].en != cen) begin
        set_box(vecs[i].bx, vecs[i].by, vecs[i].en);
        cbx = vecs[i].bx; cby = vecs[i].by; cen = vecs[i].en;
        wait_fs();
      end
      probe($sformatf("vec%0d box(%0d,%0d,%0d) px(%0d,%0d)", i, vecs[i].bx, vecs[i].by,
                      vecs[i].en, vecs[i].px, vecs[i].py),
            vecs[i].px, vecs[i].py, vecs[i].rgb);
    end

    // Asynchronous reset in the middle of the active area
    seek(30, 20, ok);
    rst_n = 1'b0;
    #1;
    check_reset("mid reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    measure_fs("re-release to frame_start");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_grid_timing.md
Name: vga_grid_timing

Overview:
- Parametrised VGA timing generator and grid renderer for the Snake display path.
- Produces H/V sync, data-enable and pixel coordinates for any mode set by parameters (default 1280x1024@60, 108 MHz pixel clock).
- Renders a one-cell red border and one green box positioned in grid-cell units.
- Box position is frame-latched so game logic may update it at any time without tearing.

Parameters:
- H_SYNC, 112, horizontal sync pulse width (pixels)
- H_BACK, 248, horizontal back porch
- H_ACTIVE, 1280, horizontal active pixels
- H_FRONT, 48, horizontal front porch (line period = sum = 1688)
- V_SYNC, 3, vertical sync pulse width (lines)
- V_BACK, 38, vertical back porch
- V_ACTIVE, 1024, vertical active lines
- V_FRONT, 1, vertical front porch (frame period = 1066)
- GRID_LOG2, 4, log2 of grid cell edge in pixels (16)
- CW, 4, bits per colour channel
- CNT_W, 12, counter/coordinate width
- CELL_W, 7, width of box cell coordinates
- HS_POL, 0, active level of O_hs
- VS_POL, 0, active level of O_vs

Ports:
- I_clk  in  1  pixel clock
- I_rst_n  in  1  async active-low reset
- I_box_x  in  CELL_W  box column in cells, 0 = leftmost cell
- I_box_y  in  CELL_W  box row in cells
- I_box_en  in  1  draw box when 1
- O_red  out  CW  red channel
- O_green  out  CW  green channel
- O_blue  out  CW  blue channel
- O_hs  out  1  horizontal sync
- O_vs  out  1  vertical sync
- O_de  out  1  active-video flag, aligned with RGB
- O_x  out  CNT_W  active pixel column, aligned with O_de
- O_y  out  CNT_W  active pixel row, aligned with O_de
- O_frame_start  out  1  one-cycle pulse at the first active pixel of each frame

Behaviour:
- Interface: reset I_rst_n, asynchronous, active-low; clock I_clk.
- Reset values:
  - h_cnt = 0, v_cnt = 0.
  - O_hs = !HS_POL, O_vs = !VS_POL.
  - O_de, O_x, O_y, O_frame_start and all RGB outputs = 0.
  - Latched box position = 0; latched enable = 0.
- Horizontal counter: h_cnt counts 0..H_total-1, then wraps to 0.
- Vertical counter: v_cnt increments only when h_cnt == H_total-1; wraps to 0 when v_cnt == V_total-1 on that same cycle.
- Sync:
  - Horizontal sync is asserted for h_cnt < H_SYNC.
  - Vertical sync is asserted for v_cnt < V_SYNC.
- Active window:
  - Horizontal: H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE.
  - Vertical: same form using the V parameters.
  - Strict upper bound: exactly H_ACTIVE x V_ACTIVE active pixels.
- Coordinates: x = h_cnt-(H_SYNC+H_BACK), y = v_cnt-(V_SYNC+V_BACK). Both are 0 outside the active window.
- Latency: every output is registered one cycle after the counter state it describes. HS, VS, DE, X, Y and RGB are mutually aligned.
- Frame latch: on the cycle with h_cnt == 0 and v_cnt == 0, I_box_x, I_box_y and I_box_en are captured. Changes at any other time take effect from the next frame only.
- Colour priority (active pixels only):
  1. Border (x>>GRID_LOG2 == 0, or == H_ACTIVE/2^GRID_LOG2-1, or the same test on y) → full red.
  2. Otherwise, latched enable and (x>>GRID_LOG2 == box_x) and (y>>GRID_LOG2 == box_y) → full green.
  3. Otherwise → black.
  - Box overlapping the border: the border wins.
  - Box out of range (cell beyond grid): nothing is drawn.
- Outside the active window, RGB = 0.
- O_frame_start: high exactly when O_de rises with O_x = 0 and O_y = 0.
- Reset mid-frame: everything returns to reset values immediately; a full frame starts at release.
- Parameter constraint: H_ACTIVE and V_ACTIVE must be multiples of 2^GRID_LOG2 (elaboration-time check).

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: adds input I_pattern (1 bit, frame-latched with the box). When latched high, the interior is drawn as 8 vertical colour bars of width H_ACTIVE/8: white, yellow, cyan, green, magenta, red, blue, black. Border and box are suppressed.
- Undefined: the port is absent and behaviour is exactly as above.

Decomposition:
- Package vga_pkg holds:
  - Timing constants for 640x480, 800x600 and 1280x1024.
  - The colour struct/typedef (r, g, b of CW).
  - Colour constants RED, GREEN, BLACK.
- Sub-module vga_timing_core holds the counters, sync, DE and coordinates. The top adds the frame latch and the colour pipeline stage.

Test Plan:
- Default parameters, run 2 frames → O_hs low for 112 of every 1688 cycles; O_vs low for 3x1688 cycles per 1066x1688-cycle frame.
- Count O_de high cycles in one frame → exactly 1,310,720; O_x spans 0..1279 and O_y spans 0..1023, each once per line/frame.
- Box (5,7), enabled → green exactly for x 80..95, y 112..127; border red at x 0..15 and 1264..1279; all other interior pixels black.
- Change box from (5,7) to (10,10) mid-frame at y=500 → current frame still shows (5,7); next frame shows (10,10).
- Box (0,0) → red only, no green; box (100,3) → nothing drawn; box disabled → no green anywhere.
- Assert I_rst_n low at h_cnt=900, v_cnt=400 → all outputs are at reset values in the same cycle; after release, O_frame_start fires 41x1688+360+1 cycles later.
